fetch_pc: RTL and testbench



---
 rtl/fetch_pc_if.sv | 24 ++
 rtl/fetch_pc.sv | 122 ++++++++++++
 tb/tb_fetch_pc.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// Split address/data instruction bus plus the decode hand-off of the fetch front end.
// The master modport is the fetch_pc side; the slave modport is the bus/decode environment.
interface fetch_pc_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_adel;

    modport master (
        output ireq_valid, ireq_addr, inst_valid, inst, inst_pc, inst_adel,
        input  ireq_addr_ok, iresp_data_ok, iresp_data, inst_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, inst_valid, inst, inst_pc, inst_adel,
        output ireq_addr_ok, iresp_data_ok, iresp_data, inst_ready
    );
endinterface

// File: rtl/fetch_pc.sv
// Fetch PC generator: issues in-order instruction requests, squashes responses from
// redirected paths and buffers returned words for decode in a small shift FIFO.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [31:0]       pcN,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    fetch_pc_if.master        bus
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } entry_t;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_cnt;
    logic          halted;
    entry_t        fifo [DEPTH];
    logic [31:0]   tag  [DEPTH];

    logic          redir;
    logic [31:0]   redir_pc;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          resp;
    logic          resp_push;
    logic          adel_push;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_wr;
    logic [CW-1:0] tag_wr;
    entry_t        push_entry;

    // NOTE: every always_comb output is assigned before any condition, so no latches are inferred.
    always_comb begin
        redir     = flush | redirect;
        redir_pc  = flush ? pcN : redirect_pc;
        occupancy = {1'b0, outstanding} + {1'b0, fifo_cnt};

        bus.ireq_valid = ~halted & ~redir & (pc[1:0] == 2'b00) & (occupancy < {1'b0, DEPTH_C});
        bus.ireq_addr  = pc;

        issue     = bus.ireq_valid & bus.ireq_addr_ok;
        resp      = bus.iresp_data_ok;
        resp_push = resp & ~redir & (drop == '0);
        adel_push = ~redir & ~halted & (pc[1:0] != 2'b00) & (outstanding == '0)
                  & (drop == '0) & (fifo_cnt != DEPTH_C);
        push      = resp_push | adel_push;
        pop       = bus.inst_valid & bus.inst_ready;

        fifo_wr = fifo_cnt - CW'(pop);
        tag_wr  = outstanding - CW'(resp);

        push_entry.inst = resp_push ? bus.iresp_data : 32'h0;
        push_entry.pc   = resp_push ? tag[0] : pc;
        push_entry.adel = ~resp_push;
    end

    always_comb begin
        bus.inst_valid = (fifo_cnt != '0);
        bus.inst       = fifo[0].inst;
        bus.inst_pc    = fifo[0].pc;
        bus.inst_adel  = fifo[0].adel;
    end

    // NOTE: tag storage has no reset; only the first 'outstanding' entries are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && tag_wr == CW'(i))
                tag[i] <= pc;
            else if (resp && i != DEPTH - 1)
                tag[i] <= tag[(i + 1) % DEPTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_cnt    <= '0;
            halted      <= 1'b0;
            // NOTE: the instruction FIFO is reset because its head drives inst/inst_pc/inst_adel.
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (redir) begin
                pc       <= redir_pc;
                halted   <= 1'b0;
                fifo_cnt <= '0;
                // Everything still in flight belongs to the squashed path.
                drop     <= outstanding - CW'(resp);
            end else begin
                if (issue)
                    pc <= pc + 32'd4;
                if (adel_push)
                    halted <= 1'b1;
                if (resp && drop != '0)
                    drop <= drop - CW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
                for (int i = 0; i < DEPTH; i++) begin
                    if (push && fifo_wr == CW'(i))
                        fifo[i] <= push_entry;
                    else if (pop)
                        fifo[i] <= (i == DEPTH - 1) ? '0 : fifo[(i + 1) % DEPTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc.sv
// Randomised scoreboard bench for fetch_pc: a transaction-level model of in-flight requests
// and delivered instructions predicts every bus request and every decode hand-off.
module tb_fetch_pc;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] pcN;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_pc_if b ();

    fetch_pc #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .pcN        (pcN),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .bus        (b)
    );

    typedef struct {
        logic [31:0] pc;
        bit          squashed;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        bit          adel;
    } ent_t;

    req_t        inflight[$];
    ent_t        exp_q[$];
    logic [31:0] exp_addr;
    bit          adel_pending;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        exp_q.delete();
        exp_addr     = RESET_PC;
        adel_pending = 1'b0;
    endtask

    // Scoreboard monitor: outputs are sampled mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (!reset) begin
            bit   redir;
            bit   exp_valid;
            bit   adel_now;
            ent_t e;
            req_t r;
            redir     = flush | redirect;
            exp_valid = !redir && (exp_addr[1:0] == 2'b00)
                        && (inflight.size() + exp_q.size() < DEPTH);
            check("inst_valid", 32'(b.inst_valid), 32'(exp_q.size() != 0));
            check("ireq_valid", 32'(b.ireq_valid), 32'(exp_valid));
            if (b.ireq_valid)
                check("ireq_addr", b.ireq_addr, exp_addr);
            if (b.inst_valid && exp_q.size() != 0) begin
                check("inst", b.inst, exp_q[0].inst);
                check("inst_pc", b.inst_pc, exp_q[0].pc);
                check("inst_adel", 32'(b.inst_adel), 32'(exp_q[0].adel));
            end

            adel_now = adel_pending && !redir && inflight.size() == 0;

            if (b.inst_valid && b.inst_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());

            if (b.iresp_data_ok) begin
                if (inflight.size() == 0) begin
                    check("resp_without_request", 32'd1, 32'd0);
                end else begin
                    r = inflight.pop_front();
                    if (!r.squashed && !redir) begin
                        e.inst = b.iresp_data;
                        e.pc   = r.pc;
                        e.adel = 1'b0;
                        exp_q.push_back(e);
                    end
                end
            end

            if (b.ireq_valid && b.ireq_addr_ok) begin
                r.pc       = b.ireq_addr;
                r.squashed = 1'b0;
                inflight.push_back(r);
                exp_addr = exp_addr + 32'd4;
            end

            if (redir) begin
                foreach (inflight[i]) inflight[i].squashed = 1'b1;
                exp_q.delete();
                exp_addr     = flush ? pcN : redirect_pc;
                adel_pending = (exp_addr[1:0] != 2'b00);
            end else if (adel_now) begin
                e.inst = 32'h0;
                e.pc   = exp_addr;
                e.adel = 1'b1;
                exp_q.push_back(e);
                adel_pending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit aok, input bit dok, input bit rdy,
                          input bit fl, input logic [31:0] fpc,
                          input bit rd, input logic [31:0] rpc);
        b.ireq_addr_ok  = aok;
        b.iresp_data_ok = dok && (inflight.size() != 0);
        b.iresp_data    = $urandom();
        b.inst_ready    = rdy;
        flush           = fl;
        pcN             = fpc;
        redirect        = rd;
        redirect_pc     = rpc;
    endtask

    task automatic run(input int n, input bit aok, input bit dok, input bit rdy);
        for (int i = 0; i < n; i++) begin
            tick();
            set_in(aok, dok, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
        end
    endtask

    task automatic do_redirect(input bit use_flush, input logic [31:0] tgt);
        tick();
        set_in(1'b1, 1'b1, 1'b1, use_flush, tgt, !use_flush, tgt);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        int          k;
        t = $urandom();
        k = $urandom_range(0, 7);
        if (k == 0)
            t[1:0] = 2'($urandom_range(1, 3));
        else if (k == 1)
            t = 32'hfffffff8;
        else
            t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        bit done;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("reset_inst_valid", 32'(b.inst_valid), 32'd0);
        check("reset_inst", b.inst, 32'h0);
        check("reset_inst_pc", b.inst_pc, 32'h0);
        check("reset_inst_adel", 32'(b.inst_adel), 32'd0);
        check("reset_ireq_addr", b.ireq_addr, RESET_PC);
        #10;
        reset = 1'b0;
        #1;
        check("first_ireq_valid", 32'(b.ireq_valid), 32'd1);
        check("first_ireq_addr", b.ireq_addr, RESET_PC);

        // Sequential fetch with an always-ready bus and decode.
        run(12, 1'b1, 1'b1, 1'b1);

        // Decode backpressure, then release.
        run(10, 1'b1, 1'b1, 1'b0);
        check("backpressure_full", 32'(exp_q.size()), 32'(DEPTH));
        check("backpressure_no_req", 32'(b.ireq_valid), 32'd0);
        run(8, 1'b1, 1'b1, 1'b1);

        // Flush with two requests in flight.
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            if (inflight.size() == 2) begin
                set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc00380, 1'b0, 32'h0);
                done = 1'b1;
            end else begin
                set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            end
        end
        check("flush_two_inflight_reached", 32'(done), 32'd1);
        run(12, 1'b1, 1'b1, 1'b1);

        // Flush coinciding with a data_ok and a FIFO pop.
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (inflight.size() != 0 && exp_q.size() != 0) begin
                set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hbfc00100, 1'b0, 32'h0);
                done = 1'b1;
            end else begin
                set_in(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            end
        end
        check("flush_with_resp_pop_reached", 32'(done), 32'd1);
        run(10, 1'b1, 1'b1, 1'b1);

        // Misaligned redirect halts until a flush.
        do_redirect(1'b0, 32'h80000002);
        run(4, 1'b1, 1'b1, 1'b0);
        run(8, 1'b1, 1'b1, 1'b1);
        check("halted_no_req", 32'(b.ireq_valid), 32'd0);
        do_redirect(1'b1, 32'hbfc00380);
        run(8, 1'b1, 1'b1, 1'b1);

        // PC wrap-around.
        do_redirect(1'b0, 32'hfffffffc);
        run(8, 1'b1, 1'b1, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            int          r;
            logic [31:0] tgt;
            tick();
            r   = $urandom_range(0, 63);
            tgt = pick_target();
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 3) != 0, r == 0, tgt, r == 1, tgt);
        end

        // Fill the FIFO, drain the bus, then reset while instructions are buffered.
        do_redirect(1'b0, 32'h00400000);
        run(6, 1'b1, 1'b1, 1'b0);
        run(10, 1'b0, 1'b1, 1'b0);
        check("drain_inflight", 32'(inflight.size()), 32'd0);
        check("fifo_occupied_before_reset", 32'(b.inst_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_reset_inst_valid", 32'(b.inst_valid), 32'd0);
        check("midrun_reset_inst_pc", b.inst_pc, 32'h0);
        check("midrun_reset_ireq_addr", b.ireq_addr, RESET_PC);
        model_reset();
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        reset = 1'b0;
        run(10, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
